// File: rtl/rom_fetch_arbiter.sv
// Round-robin sharer of a combinational instruction ROM between a fetch port (A) and a
// data/debug port (B); registers the ROM word and returns it with a one-cycle valid pulse.
module rom_fetch_arbiter #(
  parameter int unsigned TAM_ENTRADA = 1024,
  parameter int unsigned TAM_SALIDA  = 32,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned ADDR_W     = $clog2(TAM_ENTRADA)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  a_req,
  input  logic [31:0]           a_addr,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [TAM_SALIDA-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic [31:0]           b_addr,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [TAM_SALIDA-1:0] b_rdata,
  output logic                  b_err,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [TAM_SALIDA-1:0] rom_dsalida
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     rom_address_q, rom_address_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                  a_err_q, a_err_d, b_err_q, b_err_d;
  logic [TAM_SALIDA-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic        idle;
  logic        grant_a, grant_b, accept;
  logic        sel;
  logic [31:0] sel_addr;
  logic        sel_err;

  assign idle = (state_q == IDLE);

  // On a tie the port that did not win last time gets the slot.
  assign grant_a = idle & a_req & (~b_req | (last_grant_q == PORT_B));
  assign grant_b = idle & b_req & (~a_req | (last_grant_q == PORT_A));
  assign accept  = grant_a | grant_b;
  assign sel     = grant_b ? PORT_B : PORT_A;

  assign sel_addr = grant_b ? b_addr : a_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= TAM_ENTRADA);

  always_comb begin
    state_d       = state_q;
    rom_address_d = rom_address_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    a_err_d       = 1'b0;
    b_err_d       = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = sel;
          owner_d      = sel;
          if (sel_err) begin
            state_d = RESP_ERR;
          end else begin
            rom_address_d = sel_addr[ADDR_W+1:2];
            cnt_d         = WAIT_CNT;
            state_d       = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (owner_q == PORT_B) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = rom_dsalida;
          end else begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = rom_dsalida;
          end
        end
      end
      RESP_ERR: begin
        state_d = IDLE;
        if (owner_q == PORT_B) begin
          b_rvalid_d = 1'b1;
          b_err_d    = 1'b1;
          b_rdata_d  = '0;
        end else begin
          a_rvalid_d = 1'b1;
          a_err_d    = 1'b1;
          a_rdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      rom_address_q <= '0;
      cnt_q         <= '0;
      owner_q       <= PORT_A;
      last_grant_q  <= PORT_B;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_err_q       <= 1'b0;
      b_err_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_err_q       <= a_err_d;
      b_err_q       <= b_err_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_err       = a_err_q;
  assign b_err       = b_err_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign rom_address = rom_address_q;

endmodule
